// File: rtl/clock24_keeper.sv
// 24-hour time-of-day keeper: prescaled seconds/minutes/hours with edge-detected
// load from the setter, rejecting out-of-range load values.
module clock24_keeper #(
  parameter int CLK_DIV = 100000000,
  parameter int DIV_W   = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       propagate,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_pulse,
  output logic       day_wrap,
  output logic       load_error,
  output logic       time_valid
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] presc;
  logic             prop_d;
  logic             load_req;
  logic             set_legal;
  logic             load_ok;
  logic             load_bad;
  logic             tick;
  logic             advance;
  logic             sec_last;
  logic             min_last;
  logic             hr_last;

  assign load_req  = propagate & ~prop_d;
  assign set_legal = (set_hours <= 5'd23) && (set_minutes <= 6'd59);
  assign load_ok   = load_req & set_legal;
  assign load_bad  = load_req & ~set_legal;
  assign tick      = run && (presc == DIV_LAST);
  // Any load, legal or not, swallows a coincident tick.
  assign advance   = tick & ~load_req;
  assign sec_last  = (seconds == 6'd59);
  assign min_last  = (minutes == 6'd59);
  assign hr_last   = (hours == 5'd23);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prop_d     <= 1'b0;
      presc      <= '0;
      sec_pulse  <= 1'b0;
      day_wrap   <= 1'b0;
      load_error <= 1'b0;
      time_valid <= 1'b0;
    end else begin
      prop_d     <= propagate;
      sec_pulse  <= advance;
      day_wrap   <= advance & sec_last & min_last & hr_last;
      load_error <= load_bad;
      if (load_ok) begin
        presc      <= '0;
        time_valid <= 1'b1;
      end else if (run && !load_req) begin
        presc <= tick ? '0 : presc + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hours   <= '0;
      minutes <= '0;
      seconds <= '0;
    end else if (load_ok) begin
      hours   <= set_hours;
      minutes <= set_minutes;
      seconds <= '0;
    end else if (advance) begin
      if (!sec_last) begin
        seconds <= seconds + 6'd1;
      end else begin
        seconds <= '0;
        if (!min_last) begin
          minutes <= minutes + 6'd1;
        end else begin
          minutes <= '0;
          hours   <= hr_last ? 5'd0 : hours + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock24_keeper.sv
// Directed bench for clock24_keeper with CLK_DIV=4; one task per scenario,
// inputs driven and outputs sampled on the falling clock edge.
module tb_clock24_keeper;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       propagate;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       sec_pulse;
  logic       day_wrap;
  logic       load_error;
  logic       time_valid;

  int errors = 0;
  int checks = 0;

  clock24_keeper #(.CLK_DIV(4), .DIV_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .propagate  (propagate),
    .set_hours  (set_hours),
    .set_minutes(set_minutes),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .sec_pulse  (sec_pulse),
    .day_wrap   (day_wrap),
    .load_error (load_error),
    .time_valid (time_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; propagate = 1'b0;
    set_hours = '0; set_minutes = '0;
    step(); step();
    checks++;
    if ({hours, minutes, seconds, sec_pulse, day_wrap, load_error, time_valid} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got %0h exp 0",
               {hours, minutes, seconds, sec_pulse, day_wrap, load_error, time_valid});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_count();
    int npulse = 0;
    run = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (seconds !== 6'(k / 4)) begin
        errors++;
        $display("FAIL count_seconds k=%0d got %0d exp %0d", k, seconds, k / 4);
      end
      checks++;
      if (sec_pulse !== ((k % 4) == 0)) begin
        errors++;
        $display("FAIL count_pulse k=%0d got %0d exp %0d", k, sec_pulse, (k % 4) == 0);
      end
      if (sec_pulse) npulse++;
    end
    checks++;
    if (npulse != 3) begin
      errors++;
      $display("FAIL count_npulse got %0d exp 3", npulse);
    end
    checks++;
    if (time_valid !== 1'b0) begin
      errors++;
      $display("FAIL count_time_valid got %0d exp 0", time_valid);
    end
  endtask

  task automatic test_load_hold();
    set_hours = 5'd13; set_minutes = 6'd45; propagate = 1'b1;
    step();
    checks++;
    if ({hours, minutes, seconds} !== {5'd13, 6'd45, 6'd0}) begin
      errors++;
      $display("FAIL load_value got %0d:%0d:%0d exp 13:45:0", hours, minutes, seconds);
    end
    checks++;
    if (time_valid !== 1'b1) begin
      errors++;
      $display("FAIL load_time_valid got %0d exp 1", time_valid);
    end
    // Nine more cycles with propagate still high: count must progress, not reload.
    for (int k = 0; k < 9; k++) step();
    checks++;
    if ({hours, minutes, seconds} !== {5'd13, 6'd45, 6'd2}) begin
      errors++;
      $display("FAIL load_once got %0d:%0d:%0d exp 13:45:2", hours, minutes, seconds);
    end
    propagate = 1'b0; run = 1'b0;
    step();
  endtask

  task automatic test_day_wrap();
    int npulse = 0;
    int nwrap  = 0;
    set_hours = 5'd23; set_minutes = 6'd59; propagate = 1'b1;
    step();
    propagate = 1'b0; run = 1'b1;
    for (int k = 1; k <= 240; k++) begin
      step();
      if (sec_pulse) npulse++;
      if (day_wrap) begin
        nwrap++;
        checks++;
        if (k != 240 || sec_pulse !== 1'b1) begin
          errors++;
          $display("FAIL wrap_when k=%0d pulse=%0d exp k=240 pulse=1", k, sec_pulse);
        end
      end
      if (k == 236) begin
        checks++;
        if ({hours, minutes, seconds} !== {5'd23, 6'd59, 6'd59}) begin
          errors++;
          $display("FAIL wrap_pre got %0d:%0d:%0d exp 23:59:59", hours, minutes, seconds);
        end
      end
    end
    checks++;
    if ({hours, minutes, seconds} !== 17'd0) begin
      errors++;
      $display("FAIL wrap_post got %0d:%0d:%0d exp 0:0:0", hours, minutes, seconds);
    end
    checks++;
    if (nwrap != 1) begin
      errors++;
      $display("FAIL wrap_count got %0d exp 1", nwrap);
    end
    checks++;
    if (npulse != 60) begin
      errors++;
      $display("FAIL wrap_npulse got %0d exp 60", npulse);
    end
  endtask

  task automatic test_illegal();
    // Prescaler sits at 2 when the bad load lands; it must hold for that cycle.
    step(); step();
    set_hours = 5'd24; set_minutes = 6'd10; propagate = 1'b1;
    step();
    checks++;
    if (load_error !== 1'b1) begin
      errors++;
      $display("FAIL illegal_h_err got %0d exp 1", load_error);
    end
    checks++;
    if ({hours, minutes, seconds, time_valid} !== 18'd1) begin
      errors++;
      $display("FAIL illegal_h_keep got %0d:%0d:%0d v=%0d exp 0:0:0 v=1",
               hours, minutes, seconds, time_valid);
    end
    step();
    checks++;
    if (load_error !== 1'b0 || seconds !== 6'd0 || sec_pulse !== 1'b0) begin
      errors++;
      $display("FAIL illegal_h_next err=%0d s=%0d p=%0d exp 0 0 0", load_error, seconds, sec_pulse);
    end
    step();
    checks++;
    if (seconds !== 6'd1 || sec_pulse !== 1'b1) begin
      errors++;
      $display("FAIL illegal_presc_hold s=%0d p=%0d exp 1 1", seconds, sec_pulse);
    end
    run = 1'b0; propagate = 1'b0;
    step();
    set_hours = 5'd12; set_minutes = 6'd60; propagate = 1'b1;
    step();
    checks++;
    if (load_error !== 1'b1) begin
      errors++;
      $display("FAIL illegal_m_err got %0d exp 1", load_error);
    end
    checks++;
    if ({hours, minutes, seconds, time_valid} !== {5'd0, 6'd0, 6'd1, 1'b1}) begin
      errors++;
      $display("FAIL illegal_m_keep got %0d:%0d:%0d v=%0d exp 0:0:1 v=1",
               hours, minutes, seconds, time_valid);
    end
    step();
    checks++;
    if (load_error !== 1'b0) begin
      errors++;
      $display("FAIL illegal_m_once got %0d exp 0", load_error);
    end
    propagate = 1'b0;
    step();
  endtask

  task automatic test_collision();
    run = 1'b1;
    step(); step(); step();
    set_hours = 5'd5; set_minutes = 6'd6; propagate = 1'b1;
    step();
    checks++;
    if ({hours, minutes, seconds} !== {5'd5, 6'd6, 6'd0} || sec_pulse !== 1'b0 || day_wrap !== 1'b0) begin
      errors++;
      $display("FAIL collide_load got %0d:%0d:%0d p=%0d w=%0d exp 5:6:0 p=0 w=0",
               hours, minutes, seconds, sec_pulse, day_wrap);
    end
    propagate = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (sec_pulse !== (k == 4) || seconds !== 6'(k / 4)) begin
        errors++;
        $display("FAIL collide_next k=%0d p=%0d s=%0d exp p=%0d s=%0d",
                 k, sec_pulse, seconds, k == 4, k / 4);
      end
    end
  endtask

  task automatic test_run_freeze();
    int bad = 0;
    step(); step();
    run = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if ({hours, minutes, seconds} !== {5'd5, 6'd6, 6'd1} || sec_pulse || day_wrap || load_error) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL freeze got %0d bad cycles exp 0", bad);
    end
    run = 1'b1;
    step();
    step();
    checks++;
    if (seconds !== 6'd2 || sec_pulse !== 1'b1) begin
      errors++;
      $display("FAIL freeze_resume s=%0d p=%0d exp 2 1", seconds, sec_pulse);
    end
  endtask

  task automatic test_async_reset();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hours, minutes, seconds, sec_pulse, day_wrap, load_error, time_valid} !== 21'd0) begin
      errors++;
      $display("FAIL async_reset got %0h exp 0",
               {hours, minutes, seconds, sec_pulse, day_wrap, load_error, time_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (seconds !== 6'(k / 4) || sec_pulse !== (k == 4)) begin
        errors++;
        $display("FAIL post_reset k=%0d s=%0d p=%0d exp s=%0d p=%0d",
                 k, seconds, sec_pulse, k / 4, k == 4);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count();
    test_load_hold();
    test_day_wrap();
    test_illegal();
    test_collision();
    test_run_freeze();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
